data_mem: RTL

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_pkg.sv | 17 +
 rtl/data_mem_array.sv | 31 +++
 rtl/data_mem.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared access-size encodings, default geometry and dump FSM states for data_mem
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEFAULT_ADDRESS_BITS = 8;
  localparam int DEFAULT_DATA_BITS    = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_READ = 2'b01,
    DUMP_SEND = 2'b10
  } dump_state_t;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port word array with per-lane write enables and write-first registered read
module data_mem_array #(
  parameter int ADDRESS_BITS = 8,
  parameter int DATA_BITS    = 32
) (
  input  logic                      clk,
  input  logic [ADDRESS_BITS-1:0]   addr,
  input  logic                      rd_en,
  input  logic [DATA_BITS/8-1:0]    we,
  input  logic [DATA_BITS-1:0]      wdata,
  output logic [DATA_BITS-1:0]      rdata
);

  localparam int LANES    = DATA_BITS / 8;
  localparam int MEM_SIZE = 2 ** ADDRESS_BITS;

  logic [DATA_BITS-1:0] mem [MEM_SIZE];

  // Contents are deliberately not reset; rdata only moves on a read so it can be held by the caller.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) begin
        mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
      end
      if (rd_en) begin
        rdata[l*8 +: 8] <= we[l] ? wdata[l*8 +: 8] : mem[addr][l*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-lane CPU data memory with load extension; dump stream enabled by DATA_MEM_DUMP_EN
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_mem_read,
  input  logic                                        i_mem_write,
  input  logic [ADDRESS_BITS+$clog2(DATA_BITS/8)-1:0] i_address,
  input  logic [1:0]                                  i_size,
  input  logic                                        i_unsigned,
  input  logic [DATA_BITS-1:0]                        i_data,
  output logic [DATA_BITS-1:0]                        o_data,
  output logic                                        o_valid,
  output logic                                        o_misaligned,
  input  logic                                        i_dump_start,
  input  logic                                        i_dump_ready,
  output logic [DATA_BITS-1:0]                        o_dump_data,
  output logic [ADDRESS_BITS-1:0]                     o_dump_addr,
  output logic                                        o_dump_valid,
  output logic                                        o_dump_busy
);

  localparam int LANES       = DATA_BITS / 8;
  localparam int OFFSET_BITS = $clog2(LANES);

  logic [ADDRESS_BITS-1:0] word_idx;
  logic [OFFSET_BITS-1:0]  offset;
  logic                    misaligned;
  logic [LANES-1:0]        lane_mask;
  logic                    dump_busy;
  logic                    dump_rd;
  logic [ADDRESS_BITS-1:0] dump_ptr;
  logic                    do_write;
  logic                    do_read;
  logic                    bad_req;
  logic [ADDRESS_BITS-1:0] arr_addr;
  logic [LANES-1:0]        arr_we;
  logic [DATA_BITS-1:0]    arr_wdata;
  logic [DATA_BITS-1:0]    arr_rdata;

  logic                    ld_pend;
  logic                    mis_pend;
  logic [1:0]              ld_size;
  logic [OFFSET_BITS-1:0]  ld_off;
  logic                    ld_uns;
  logic [DATA_BITS-1:0]    shifted;
  logic [DATA_BITS-1:0]    ld_result;

  assign word_idx = i_address[ADDRESS_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign offset   = i_address[OFFSET_BITS-1:0];

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = '1;
    case (i_size)
      SIZE_BYTE: lane_mask = LANES'(1) << offset;
      SIZE_HALF: begin
        misaligned = offset[0];
        lane_mask  = LANES'(3) << offset;
      end
      default:   misaligned = (offset != '0);
    endcase
  end

  // The dump owns the single array port while busy, so CPU traffic is simply dropped.
  assign bad_req  = (i_mem_read | i_mem_write) & ~dump_busy & misaligned;
  assign do_write = i_mem_write & ~dump_busy & ~misaligned;
  assign do_read  = i_mem_read & ~i_mem_write & ~dump_busy & ~misaligned;

  assign arr_addr  = dump_rd ? dump_ptr : word_idx;
  assign arr_we    = do_write ? lane_mask : '0;
  assign arr_wdata = i_data << {offset, 3'b000};

  data_mem_array #(
    .ADDRESS_BITS(ADDRESS_BITS),
    .DATA_BITS   (DATA_BITS)
  ) u_array (
    .clk  (clk),
    .addr (arr_addr),
    .rd_en(do_read | dump_rd),
    .we   (arr_we),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    shifted = arr_rdata >> {ld_off, 3'b000};
    case (ld_size)
      SIZE_BYTE: ld_result = ld_uns ? {{(DATA_BITS-8){1'b0}}, shifted[7:0]}
                                    : {{(DATA_BITS-8){shifted[7]}}, shifted[7:0]};
      SIZE_HALF: ld_result = ld_uns ? {{(DATA_BITS-16){1'b0}}, shifted[15:0]}
                                    : {{(DATA_BITS-16){shifted[15]}}, shifted[15:0]};
      default:   ld_result = arr_rdata;
    endcase
  end

  // Stage 1 records what was asked while the array reads; stage 2 extends and publishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_pend      <= 1'b0;
      mis_pend     <= 1'b0;
      ld_size      <= SIZE_WORD;
      ld_off       <= '0;
      ld_uns       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      ld_pend  <= do_read;
      mis_pend <= bad_req;
      if (do_read) begin
        ld_size <= i_size;
        ld_off  <= offset;
        ld_uns  <= i_unsigned;
      end
      o_valid      <= ld_pend;
      o_misaligned <= mis_pend;
      if (ld_pend) begin
        o_data <= ld_result;
      end
    end
  end

`ifdef DATA_MEM_DUMP_EN
  dump_state_t             dump_state;
  dump_state_t             dump_state_nx;
  logic [ADDRESS_BITS-1:0] dump_ptr_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_state <= DUMP_IDLE;
      dump_ptr   <= '0;
    end else begin
      dump_state <= dump_state_nx;
      dump_ptr   <= dump_ptr_nx;
    end
  end

  always_comb begin
    dump_state_nx = dump_state;
    dump_ptr_nx   = dump_ptr;
    dump_busy     = 1'b1;
    dump_rd       = 1'b0;
    o_dump_valid  = 1'b0;
    o_dump_data   = '0;
    o_dump_addr   = '0;
    case (dump_state)
      DUMP_IDLE: begin
        dump_busy = 1'b0;
        if (i_dump_start) begin
          dump_state_nx = DUMP_READ;
          dump_ptr_nx   = '0;
        end
      end
      DUMP_READ: begin
        dump_rd       = 1'b1;
        dump_state_nx = DUMP_SEND;
      end
      DUMP_SEND: begin
        // arr_rdata holds here because nothing else may read the array while busy.
        o_dump_valid = 1'b1;
        o_dump_data  = arr_rdata;
        o_dump_addr  = dump_ptr;
        if (i_dump_ready) begin
          if (&dump_ptr) begin
            dump_state_nx = DUMP_IDLE;
          end else begin
            dump_ptr_nx   = dump_ptr + 1'b1;
            dump_state_nx = DUMP_READ;
          end
        end
      end
      default: dump_state_nx = DUMP_IDLE;
    endcase
  end
`else
  logic unused_dump_inputs;

  assign unused_dump_inputs = i_dump_start ^ i_dump_ready;
  assign dump_busy    = 1'b0;
  assign dump_rd      = 1'b0;
  assign dump_ptr     = '0;
  assign o_dump_valid = 1'b0;
  assign o_dump_data  = '0;
  assign o_dump_addr  = '0;
`endif

  assign o_dump_busy = dump_busy;

endmodule
